// File: rtl/snd_pkg.sv
// Shared definitions for the sound command path (main-CPU transmitter and sound-side latch).
package snd_pkg;

   typedef logic [7:0] snd_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ASSERT,
      ST_WAIT_ACK,
      ST_GAP
   } snd_state_t;

   localparam int unsigned SND_DEPTH    = 4;
   localparam int unsigned SND_NMI_HOLD = 32;
   localparam int unsigned SND_TIMEOUT  = 4096;
   localparam int unsigned SND_GAP      = 8;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/snd_cmd_fifo.sv
// DEPTH x 8 synchronous command FIFO; pointers carry one extra wrap bit for full/empty.
module snd_cmd_fifo
   import snd_pkg::*;
#(
   parameter int unsigned DEPTH = SND_DEPTH
) (
   input  logic     clk_sys,
   input  logic     reset_n,
   input  logic     push,
   input  logic     pop,
   input  snd_cmd_t din,
   output snd_cmd_t head,
   output logic     full,
   output logic     empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   snd_cmd_t     mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage has no reset: contents are only observable after a push.
   always_ff @(posedge clk_sys) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/snd_cmd_tx.sv
// Main-CPU sound command transmitter: queues command bytes and signals them one at a
// time to the sound CPU, waiting for its latch-read acknowledge between bytes.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_IDLE     | nothing in flight; pops FIFO head into snd_data when non-empty
// ST_LOAD     | snd_data settled for one cycle before snd_write rises
// ST_ASSERT   | snd_write high for NMI_HOLD cycles, early acks remembered
// ST_WAIT_ACK | snd_write low, waiting for snd_ack or TIMEOUT cycles
// ST_GAP      | GAP idle cycles before the next command may start
module snd_cmd_tx
   import snd_pkg::*;
#(
   parameter int unsigned DEPTH    = SND_DEPTH,
   parameter int unsigned NMI_HOLD = SND_NMI_HOLD,
   parameter int unsigned TIMEOUT  = SND_TIMEOUT,
   parameter int unsigned GAP      = SND_GAP
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       cmd_wr,
   input  logic [7:0] cmd_din,
   input  logic       snd_ack,
   input  logic       ovf_clr,
   output logic       snd_write,
   output logic [7:0] snd_data,
   output logic       fifo_full,
   output logic       busy,
   output logic       ovf,
   output logic       tmo
);

   localparam int unsigned CNT_MAX = max3(NMI_HOLD, TIMEOUT, GAP);
   localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

   localparam logic [CW-1:0] HOLD_LAST = CW'(NMI_HOLD - 1);
   localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

   snd_state_t    state;
   logic [CW-1:0] cnt;
   logic          ack_seen;

   snd_cmd_t      head;
   logic          full;
   logic          empty;
   logic          pop;
   logic          push;

   assign pop  = (state == ST_IDLE) && !empty;
   // A write into a full FIFO still lands if the head leaves in the same cycle.
   assign push = cmd_wr && (!full || pop);

   snd_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (cmd_din),
      .head    (head),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         ack_seen  <= 1'b0;
         snd_write <= 1'b0;
         snd_data  <= '0;
         tmo       <= 1'b0;
      end else begin
         if (ovf_clr) tmo <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  snd_data <= head;
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               ack_seen  <= 1'b0;
               cnt       <= '0;
               snd_write <= 1'b1;
               state     <= ST_ASSERT;
            end
            ST_ASSERT: begin
               if (cnt == HOLD_LAST) begin
                  cnt       <= '0;
                  snd_write <= 1'b0;
                  state     <= (ack_seen || snd_ack) ? ST_GAP : ST_WAIT_ACK;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (snd_ack) ack_seen <= 1'b1;
               end
            end
            ST_WAIT_ACK: begin
               if (snd_ack) begin
                  cnt   <= '0;
                  state <= ST_GAP;
               end else if (cnt == TMO_LAST) begin
                  tmo   <= 1'b1;
                  cnt   <= '0;
                  state <= ST_GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // A same-cycle drop outranks the clear.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         ovf <= 1'b0;
      end else if (cmd_wr && full && !pop) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

   assign fifo_full = full;
   assign busy      = (state != ST_IDLE) || !empty;

endmodule
